pad_bank_ctrl: RTL and testbench

Parametrised controller for a bank of NCH bidirectional pads built from PADBID cells. It sits between core logic and the PADBID I/OEN/C pins. Each channel has its own direction state machine with a programmable bus-turnaround dead time, a multi-stage input synchroniser, and a sticky contention detector that compares driven and received values. This is the sequential successor to hand-instantiated PADBID/TBUF groups with per-bit enables.

---
 rtl/pad_bank_ctrl.sv | 127 ++++++++++++
 tb/tb_pad_bank_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pad_bank_ctrl.sv
// Controller for a bank of NCH PADBID cells: per-channel direction FSM with
// turnaround dead time, input synchroniser and sticky drive-contention flag.
module pad_bank_ctrl #(
  parameter int NCH         = 4,
  parameter int TURN_CYC    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic           CK,
  input  logic           RST,
  input  logic [NCH-1:0] oe_req,
  input  logic [NCH-1:0] dout,
  input  logic [NCH-1:0] err_clr,
  input  logic [NCH-1:0] pad_c,
  output logic [NCH-1:0] pad_i,
  output logic [NCH-1:0] pad_oen,
  output logic [NCH-1:0] din,
  output logic [NCH-1:0] din_valid,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] err
);

  localparam logic [1:0] ST_RX      = 2'd0;
  localparam logic [1:0] ST_TURN_TX = 2'd1;
  localparam logic [1:0] ST_TX      = 2'd2;
  localparam logic [1:0] ST_TURN_RX = 2'd3;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC);
  localparam logic [2:0] RX_FULL   = 3'(SYNC_STAGES);
  localparam logic [2:0] SETTLE    = 3'(SYNC_STAGES + 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) pad_i <= '0;
    else     pad_i <= dout;
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [1:0]             state;
    logic [1:0]             state_nx;
    logic [3:0]             cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] pad_i_dly;
    logic [2:0]             rx_cnt;
    logic [2:0]             settle_cnt;
    logic                   oen_q;
    logic                   valid_q;
    logic                   err_q;
    logic                   mism;

    // NOTE: next-state defaults to the current state before the case so no
    // path leaves state_nx unassigned (which would infer a latch).
    always_comb begin
      state_nx = state;
      case (state)
        ST_RX:      if (oe_req[ch]) state_nx = ST_TURN_TX;
        ST_TURN_TX: if (cnt == 4'd1) state_nx = oe_req[ch] ? ST_TX : ST_TURN_RX;
        ST_TX:      if (!oe_req[ch]) state_nx = ST_TURN_RX;
        ST_TURN_RX: if (cnt == 4'd1) state_nx = oe_req[ch] ? ST_TURN_TX : ST_RX;
        default:    state_nx = ST_RX;
      endcase
    end

    // Turn states reload on every entry; the request is only looked at on expiry.
    always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
        state <= ST_RX;
        cnt   <= '0;
        oen_q <= 1'b1;
      end else begin
        state <= state_nx;
        oen_q <= (state_nx != ST_TX);
        if ((state_nx == ST_TURN_TX || state_nx == ST_TURN_RX) && state_nx != state)
          cnt <= TURN_LOAD;
        else if (state == ST_TURN_TX || state == ST_TURN_RX)
          cnt <= cnt - 4'd1;
      end
    end

    always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
        sync_q    <= '0;
        pad_i_dly <= '0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], pad_c[ch]};
        pad_i_dly <= {pad_i_dly[SYNC_STAGES-2:0], pad_i[ch]};
      end
    end

    // din is trustworthy once the synchroniser has been filled from the pad in RX.
    always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
        rx_cnt  <= '0;
        valid_q <= 1'b0;
      end else if (state_nx != ST_RX || state != ST_RX) begin
        rx_cnt  <= '0;
        valid_q <= 1'b0;
      end else begin
        if (rx_cnt != RX_FULL) rx_cnt <= rx_cnt + 3'd1;
        valid_q <= valid_q | ((rx_cnt + 3'd1) >= RX_FULL);
      end
    end

    always_ff @(posedge CK or posedge RST) begin
      if (RST)                                       settle_cnt <= '0;
      else if (state_nx != ST_TX || state != ST_TX)  settle_cnt <= '0;
      else if (settle_cnt != SETTLE)                 settle_cnt <= settle_cnt + 3'd1;
    end

    // Received value is compared against what was driven SYNC_STAGES cycles ago.
    assign mism = (state == ST_TX) && (settle_cnt >= SETTLE) &&
                  (sync_q[SYNC_STAGES-1] != pad_i_dly[SYNC_STAGES-1]);

    always_ff @(posedge CK or posedge RST) begin
      if (RST)              err_q <= 1'b0;
      else if (mism)        err_q <= 1'b1;
      else if (err_clr[ch]) err_q <= 1'b0;
    end

    assign pad_oen[ch]   = oen_q;
    assign din[ch]       = sync_q[SYNC_STAGES-1];
    assign din_valid[ch] = valid_q;
    assign busy[ch]      = (state == ST_TURN_TX) || (state == ST_TURN_RX);
    assign err[ch]       = err_q;
  end

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Self-checking bench for pad_bank_ctrl: a 4-channel default instance with a
// pad loopback/fault model, plus an 8-channel TURN_CYC=15 instance under random requests.
module tb_pad_bank_ctrl;

  localparam int S = 2;

  logic CK = 1'b0;
  logic RST;

  logic [3:0] oe_req, dout, err_clr, pad_c, pad_i, pad_oen, din, din_valid, busy, err;
  logic [3:0] ext, fault, fault_val;
  logic [7:0] oe_req8, dout8, err_clr8, pad_c8, pad_i8, pad_oen8, din8, din_valid8, busy8, err8;

  int checks   = 0;
  int failures = 0;

  always #5 CK = ~CK;

  pad_bank_ctrl #(.NCH(4), .TURN_CYC(2), .SYNC_STAGES(2)) u_dut (
    .CK(CK), .RST(RST), .oe_req(oe_req), .dout(dout), .err_clr(err_clr),
    .pad_c(pad_c), .pad_i(pad_i), .pad_oen(pad_oen), .din(din),
    .din_valid(din_valid), .busy(busy), .err(err)
  );

  pad_bank_ctrl #(.NCH(8), .TURN_CYC(15), .SYNC_STAGES(2)) u_dut8 (
    .CK(CK), .RST(RST), .oe_req(oe_req8), .dout(dout8), .err_clr(err_clr8),
    .pad_c(pad_c8), .pad_i(pad_i8), .pad_oen(pad_oen8), .din(din8),
    .din_valid(din_valid8), .busy(busy8), .err(err8)
  );

  // Pad model: a driven pad reads back its own value unless a fault overrides it.
  always_comb begin
    pad_c = ext;
    for (int i = 0; i < 4; i++) begin
      if (fault[i])        pad_c[i] = fault_val[i];
      else if (!pad_oen[i]) pad_c[i] = pad_i[i];
    end
  end

  assign pad_c8 = pad_i8 & ~pad_oen8;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (pad_oen !== 4'hF) begin failures++; $display("FAIL reset_oen got=%h exp=f", pad_oen); end
    checks++; if ({pad_i, din, din_valid, busy, err} !== 20'h0) begin failures++; $display("FAIL reset_zero got=%h exp=0", {pad_i, din, din_valid, busy, err}); end
    checks++; if (pad_oen8 !== 8'hFF) begin failures++; $display("FAIL reset_oen8 got=%h exp=ff", pad_oen8); end
    tick(); tick();
    RST = 1'b0;
    tick();
    checks++; if (din_valid !== 4'h0) begin failures++; $display("FAIL valid_early got=%h exp=0", din_valid); end
    tick();
    checks++; if (din_valid !== 4'hF) begin failures++; $display("FAIL valid_rise got=%h exp=f", din_valid); end
    checks++; if (din_valid8 !== 8'hFF) begin failures++; $display("FAIL valid_rise8 got=%h exp=ff", din_valid8); end
  endtask

  task automatic test_turn_tx();
    int fall = -1, rise = -1, vat = -1, nbusy = 0;
    dout[1] = 1'b1;
    oe_req[1] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (busy[1]) nbusy++;
      if (fall < 0 && pad_oen[1] == 1'b0) fall = c;
      if (c == 1) begin
        checks++; if (din_valid[1] !== 1'b0) begin failures++; $display("FAIL tx_valid_clear got=%b exp=0", din_valid[1]); end
      end
    end
    checks++; if (fall !== 3) begin failures++; $display("FAIL tx_oen_fall got=%0d exp=3", fall); end
    checks++; if (nbusy !== 2) begin failures++; $display("FAIL tx_busy_len got=%0d exp=2", nbusy); end
    checks++; if (pad_i[1] !== 1'b1) begin failures++; $display("FAIL tx_pad_i got=%b exp=1", pad_i[1]); end
    checks++; if ((pad_oen & 4'b1101) !== 4'b1101) begin failures++; $display("FAIL tx_indep got=%h exp=d", pad_oen & 4'b1101); end
    checks++; if (err !== 4'h0) begin failures++; $display("FAIL tx_no_err got=%h exp=0", err); end
    oe_req[1] = 1'b0;
    nbusy = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (busy[1]) nbusy++;
      if (rise < 0 && pad_oen[1] == 1'b1) rise = c;
      if (vat < 0 && din_valid[1] == 1'b1) vat = c;
    end
    checks++; if (rise !== 1) begin failures++; $display("FAIL rx_oen_rise got=%0d exp=1", rise); end
    checks++; if (nbusy !== 2) begin failures++; $display("FAIL rx_busy_len got=%0d exp=2", nbusy); end
    checks++; if (vat !== 5) begin failures++; $display("FAIL rx_valid_at got=%0d exp=5", vat); end
  endtask

  task automatic test_short_pulse();
    int nbusy = 0;
    logic oen_low = 1'b0;
    oe_req[2] = 1'b1;
    tick();
    if (busy[2]) nbusy++;
    if (!pad_oen[2]) oen_low = 1'b1;
    oe_req[2] = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (busy[2]) nbusy++;
      if (!pad_oen[2]) oen_low = 1'b1;
    end
    checks++; if (oen_low !== 1'b0) begin failures++; $display("FAIL pulse_never_drive got=%b exp=0", oen_low); end
    checks++; if (nbusy !== 4) begin failures++; $display("FAIL pulse_busy_len got=%0d exp=4", nbusy); end
    checks++; if (din_valid[2] !== 1'b1) begin failures++; $display("FAIL pulse_back_rx got=%b exp=1", din_valid[2]); end
  endtask

  task automatic test_rx_sync();
    logic expq[$];
    logic [11:0] pat;
    logic exp_b;
    pat = 12'b1011_0011_0101;
    for (int i = 0; i < 12; i++) begin
      ext[3] = pat[i];
      expq.push_back(pat[i]);
      tick();
      if (expq.size() == S) begin
        exp_b = expq.pop_front();
        checks++; if (din[3] !== exp_b) begin failures++; $display("FAIL sync_din[%0d] got=%b exp=%b", i, din[3], exp_b); end
        checks++; if (din_valid[3] !== 1'b1) begin failures++; $display("FAIL sync_valid[%0d] got=%b exp=1", i, din_valid[3]); end
      end
    end
    while (expq.size() > 0) begin
      tick();
      exp_b = expq.pop_front();
      checks++; if (din[3] !== exp_b) begin failures++; $display("FAIL sync_drain got=%b exp=%b", din[3], exp_b); end
    end
  endtask

  task automatic test_contention();
    dout[0] = 1'b1;
    fault[0] = 1'b1;
    fault_val[0] = 1'b0;
    oe_req[0] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 3) begin
        checks++; if (pad_oen[0] !== 1'b0) begin failures++; $display("FAIL cont_tx got=%b exp=0", pad_oen[0]); end
      end
      if (c == 6) begin
        checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL cont_early got=%b exp=0", err[0]); end
      end
    end
    checks++; if (err !== 4'b0001) begin failures++; $display("FAIL cont_rise got=%h exp=1", err); end
    err_clr[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (err[0] !== 1'b1) begin failures++; $display("FAIL cont_set_wins got=%b exp=1", err[0]); end
    end
    err_clr[0] = 1'b0;
    fault[0] = 1'b0;
    repeat (4) tick();
    checks++; if (err[0] !== 1'b1) begin failures++; $display("FAIL cont_sticky got=%b exp=1", err[0]); end
    oe_req[0] = 1'b0;
    repeat (6) tick();
    checks++; if ({err[0], busy[0], pad_oen[0]} !== 3'b101) begin failures++; $display("FAIL cont_state_change got=%b exp=101", {err[0], busy[0], pad_oen[0]}); end
    err_clr[0] = 1'b1;
    tick();
    err_clr[0] = 1'b0;
    checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL cont_clear got=%b exp=0", err[0]); end
    tick();
    checks++; if (err !== 4'h0) begin failures++; $display("FAIL cont_stay_clear got=%h exp=0", err); end
  endtask

  task automatic test_random8();
    int run [8];
    logic seen_tx [8];
    logic prev [8];
    int need, nfalls = 0;
    for (int ch = 0; ch < 8; ch++) begin
      run[ch] = 0; seen_tx[ch] = 1'b0; prev[ch] = 1'b1;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int ch = 0; ch < 8; ch++)
        if ($urandom_range(0, 39) == 0) oe_req8[ch] = ~oe_req8[ch];
      dout8 = 8'($urandom);
      tick();
      for (int ch = 0; ch < 8; ch++) begin
        if (pad_oen8[ch] == 1'b0 && prev[ch] == 1'b1) begin
          need = seen_tx[ch] ? 30 : 15;
          nfalls++;
          checks++; if (run[ch] < need) begin failures++; $display("FAIL rand_dead ch=%0d got=%0d exp>=%0d", ch, run[ch], need); end
          seen_tx[ch] = 1'b1;
          run[ch] = 0;
        end else if (pad_oen8[ch] == 1'b1) begin
          run[ch]++;
        end
        prev[ch] = pad_oen8[ch];
      end
    end
    oe_req8 = '0;
    checks++; if (nfalls == 0) begin failures++; $display("FAIL rand_reached_tx got=0 exp>0"); end
    checks++; if (err8 !== 8'h00) begin failures++; $display("FAIL rand_no_err got=%h exp=00", err8); end
  endtask

  task automatic test_async_reset();
    oe_req[0] = 1'b1;
    repeat (3) tick();
    checks++; if (pad_oen[0] !== 1'b0) begin failures++; $display("FAIL areset_pre got=%b exp=0", pad_oen[0]); end
    @(posedge CK);
    #3 RST = 1'b1;
    #1;
    checks++; if (pad_oen !== 4'hF) begin failures++; $display("FAIL areset_oen got=%h exp=f", pad_oen); end
    checks++; if (pad_oen8 !== 8'hFF) begin failures++; $display("FAIL areset_oen8 got=%h exp=ff", pad_oen8); end
    oe_req[0] = 1'b0;
    #2 RST = 1'b0;
    tick();
    checks++; if ({pad_oen, busy, din_valid} !== 12'hF00) begin failures++; $display("FAIL areset_rx got=%h exp=f00", {pad_oen, busy, din_valid}); end
    tick();
    checks++; if (din_valid !== 4'hF) begin failures++; $display("FAIL areset_valid got=%h exp=f", din_valid); end
  endtask

  initial begin
    RST = 1'b1;
    oe_req = '0; dout = '0; err_clr = '0;
    ext = '0; fault = '0; fault_val = '0;
    oe_req8 = '0; dout8 = '0; err_clr8 = '0;
    test_reset();
    test_turn_tx();
    test_short_pulse();
    test_rx_sync();
    test_contention();
    test_random8();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog elapsed before summary");
    $fatal(1, "watchdog");
  end

endmodule
